// File: rtl/axil_read_master.sv
// -----------------------------------------------------------------------------
// axil_read_master
//
// Single-outstanding AXI4-Lite read master. Each byte address accepted on the
// command stream becomes one AR/R transaction; the captured read data and
// response code are returned on the response stream. A per-phase timeout
// turns a dead or unmapped slave into a DECERR response so that the host
// never hangs.
//
// Parameters
//   ADDR_WIDTH  width of cmd_tdata and m_araddr
//   DATA_WIDTH  width of m_rdata and rsp_tdata
//   TIMEOUT     cycles allowed in the AR phase and in the R phase before
//               aborting; 0 disables the timeout
//
// Ports
//   aclk, aresetn            rising-edge clock, synchronous active-low reset
//   cmd_tvalid/tready/tdata  read command stream (byte address)
//   m_ar*                    AXI4-Lite read address channel
//   m_r*                     AXI4-Lite read data channel
//   rsp_tvalid/tready        response stream handshake
//   rsp_tdata                captured read data (0 on timeout)
//   rsp_tuser                captured rresp (2'b11 DECERR on timeout)
//
// Every output is a register, so there is no combinational path from any
// input to any output.
// -----------------------------------------------------------------------------
module axil_read_master #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  // command stream
  input  logic                  cmd_tvalid,
  output logic                  cmd_tready,
  input  logic [ADDR_WIDTH-1:0] cmd_tdata,
  // AXI4-Lite read address channel
  output logic                  m_arvalid,
  input  logic                  m_arready,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  // AXI4-Lite read data channel
  input  logic                  m_rvalid,
  output logic                  m_rready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp,
  // response stream
  output logic                  rsp_tvalid,
  input  logic                  rsp_tready,
  output logic [DATA_WIDTH-1:0] rsp_tdata,
  output logic [1:0]            rsp_tuser
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [1:0] RESP_DECERR = 2'b11;

  // One extra bit over clog2 so the counter can saturate without wrapping
  // even when TIMEOUT is a power of two.
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] TMR_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] TMR_MAX  = {CW{1'b1}};

  logic [1:0]    state;
  logic [CW-1:0] tmr;
  logic [CW-1:0] tmr_inc;
  logic          expire;

  // Saturating increment: the counter never wraps back into a live range.
  assign tmr_inc = (tmr == TMR_MAX) ? tmr : tmr + CW'(1);

  // Expiry is only meaningful with the timeout enabled; with TIMEOUT=0 the
  // FSM waits for the slave indefinitely.
  assign expire = (TIMEOUT > 0) && (tmr == TMR_LAST);

  // NOTE: reset is sampled on the clock edge (synchronous), and all state is
  // updated with non-blocking assignments so every register sees the
  // pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state      <= S_IDLE;
      cmd_tready <= 1'b0;
      m_arvalid  <= 1'b0;
      m_araddr   <= '0;
      m_rready   <= 1'b0;
      rsp_tvalid <= 1'b0;
      rsp_tdata  <= '0;
      rsp_tuser  <= '0;
      tmr        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // Ready for commands; rready stays high so a stale beat from a
          // timed-out read is swallowed here and never reaches rsp.
          cmd_tready <= 1'b1;
          m_rready   <= 1'b1;
          if (cmd_tvalid && cmd_tready) begin
            m_araddr   <= cmd_tdata;
            m_arvalid  <= 1'b1;
            cmd_tready <= 1'b0;
            m_rready   <= 1'b0;
            tmr        <= '0;
            state      <= S_ADDR;
          end
        end

        S_ADDR: begin
          // m_arvalid is high throughout ADDR, so arready alone completes
          // the handshake. A handshake on the expiry cycle takes priority.
          if (m_arready) begin
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
            tmr       <= '0;
            state     <= S_DATA;
          end else if (expire) begin
            m_arvalid  <= 1'b0;
            rsp_tvalid <= 1'b1;
            rsp_tdata  <= '0;
            rsp_tuser  <= RESP_DECERR;
            state      <= S_RESP;
          end else begin
            tmr <= tmr_inc;
          end
        end

        S_DATA: begin
          if (m_rvalid) begin
            m_rready   <= 1'b0;
            rsp_tvalid <= 1'b1;
            rsp_tdata  <= m_rdata;
            rsp_tuser  <= m_rresp;
            state      <= S_RESP;
          end else if (expire) begin
            m_rready   <= 1'b0;
            rsp_tvalid <= 1'b1;
            rsp_tdata  <= '0;
            rsp_tuser  <= RESP_DECERR;
            state      <= S_RESP;
          end else begin
            tmr <= tmr_inc;
          end
        end

        S_RESP: begin
          // No timeout here: the consumer may stall for as long as it likes.
          if (rsp_tready) begin
            rsp_tvalid <= 1'b0;
            cmd_tready <= 1'b1;
            m_rready   <= 1'b1;
            state      <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_read_master.sv
// -----------------------------------------------------------------------------
// tb_axil_read_master
//
// Directed and randomized bench for axil_read_master (TIMEOUT=16). A task
// plays slave and response consumer for one read at a time; the expected
// response and its handshake cycle come from a transaction-level model that
// works only from the delays chosen for each read.
// -----------------------------------------------------------------------------
module tb_axil_read_master;

  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          cmd_tvalid;
  logic          cmd_tready;
  logic [AW-1:0] cmd_tdata;
  logic          m_arvalid;
  logic          m_arready;
  logic [AW-1:0] m_araddr;
  logic          m_rvalid;
  logic          m_rready;
  logic [DW-1:0] m_rdata;
  logic [1:0]    m_rresp;
  logic          rsp_tvalid;
  logic          rsp_tready;
  logic [DW-1:0] rsp_tdata;
  logic [1:0]    rsp_tuser;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    user;
    int            hs_cyc;
  } rsp_t;

  rsp_t obs_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  axil_read_master #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TMO)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .cmd_tvalid (cmd_tvalid),
    .cmd_tready (cmd_tready),
    .cmd_tdata  (cmd_tdata),
    .m_arvalid  (m_arvalid),
    .m_arready  (m_arready),
    .m_araddr   (m_araddr),
    .m_rvalid   (m_rvalid),
    .m_rready   (m_rready),
    .m_rdata    (m_rdata),
    .m_rresp    (m_rresp),
    .rsp_tvalid (rsp_tvalid),
    .rsp_tready (rsp_tready),
    .rsp_tdata  (rsp_tdata),
    .rsp_tuser  (rsp_tuser)
  );

  initial forever #5 aclk = ~aclk;

  // Edge counter plus response monitor: records every rsp handshake with the
  // index of the edge on which it happened.
  initial forever begin
    @(posedge aclk);
    cyc++;
    if (rsp_tvalid && rsp_tready) begin
      rsp_t o;
      o.data   = rsp_tdata;
      o.user   = rsp_tuser;
      o.hs_cyc = cyc;
      obs_q.push_back(o);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Transaction-level reference: a phase that needs TMO or more cycles of
  // waiting is aborted with DECERR and zero data; otherwise the slave's
  // data and response pass through untouched.
  function automatic rsp_t model_rsp(input int ar_dly, input int r_dly,
                                     input logic [DW-1:0] d, input logic [1:0] r);
    rsp_t m;
    if (ar_dly >= TMO || r_dly >= TMO) begin
      m.data = '0;
      m.user = 2'b11;
    end else begin
      m.data = d;
      m.user = r;
    end
    m.hs_cyc = 0;
    return m;
  endfunction

  // One complete read. ar_dly/r_dly are wait cycles before the slave
  // asserts arready/rvalid; rsp_dly is cycles of consumer backpressure.
  task automatic run_read(input logic [AW-1:0] addr, input int ar_dly, input int r_dly,
                          input int rsp_dly, input logic [DW-1:0] data, input logic [1:0] resp,
                          input bit hold_valid, input logic [AW-1:0] next_addr,
                          output int acc_cyc);
    rsp_t exp_r;
    rsp_t o;
    int   n_ar;
    int   n_r;
    int   w;
    bit   to_ar;
    bit   to_r;

    to_ar = (ar_dly >= TMO);
    to_r  = !to_ar && (r_dly >= TMO);
    n_ar  = to_ar ? TMO : ar_dly + 1;
    n_r   = to_ar ? 0 : (to_r ? TMO : r_dly + 1);
    exp_r = model_rsp(ar_dly, r_dly, data, resp);

    cmd_tvalid = 1'b1;
    cmd_tdata  = addr;
    w = 0;
    while (!cmd_tready && w < 40) begin
      @(negedge aclk);
      w++;
    end
    check("cmd_tready_idle", 64'(cmd_tready), 64'd1);
    acc_cyc      = cyc + 1;
    exp_r.hs_cyc = acc_cyc + n_ar + n_r + rsp_dly + 1;
    @(negedge aclk);
    if (hold_valid) cmd_tdata = next_addr;
    else            cmd_tvalid = 1'b0;
    check("cmd_tready_busy", 64'(cmd_tready), 64'd0);

    // Address phase; m_rvalid noise must be ignored while rready is low.
    for (int k = 1; k <= n_ar; k++) begin
      check("arvalid_addr", 64'(m_arvalid), 64'd1);
      check("araddr_stable", 64'(m_araddr), 64'(addr));
      check("rready_addr", 64'(m_rready), 64'd0);
      m_rvalid  = 1'($urandom_range(0, 1));
      m_rdata   = $urandom;
      m_rresp   = 2'($urandom);
      m_arready = (!to_ar && k == n_ar);
      @(negedge aclk);
    end
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    check("arvalid_drop", 64'(m_arvalid), 64'd0);

    // Data phase (skipped when the address phase aborted).
    for (int k = 1; k <= n_r; k++) begin
      check("rready_data", 64'(m_rready), 64'd1);
      if (!to_r && k == n_r) begin
        m_rvalid = 1'b1;
        m_rdata  = data;
        m_rresp  = resp;
      end
      @(negedge aclk);
      m_rvalid = 1'b0;
    end

    // Response phase with backpressure; outputs must hold steady.
    for (int k = 0; k <= rsp_dly; k++) begin
      check("rsp_tvalid_resp", 64'(rsp_tvalid), 64'd1);
      check("rsp_tdata_hold", 64'(rsp_tdata), 64'(exp_r.data));
      check("rsp_tuser_hold", 64'(rsp_tuser), 64'(exp_r.user));
      check("rready_resp", 64'(m_rready), 64'd0);
      rsp_tready = (k == rsp_dly);
      @(negedge aclk);
    end
    rsp_tready = 1'b0;
    check("rsp_tvalid_done", 64'(rsp_tvalid), 64'd0);
    check("cmd_tready_after", 64'(cmd_tready), 64'd1);
    check("rready_idle", 64'(m_rready), 64'd1);

    check("rsp_count", 64'(obs_q.size()), 64'd1);
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      check("rsp_q_data", 64'(o.data), 64'(exp_r.data));
      check("rsp_q_user", 64'(o.user), 64'(exp_r.user));
      check("rsp_hs_cycle", 64'(o.hs_cyc), 64'(exp_r.hs_cyc));
    end
  endtask

  initial begin
    int a0;
    int a1;
    int a2;
    int a3;
    logic [1:0] resp_tab [3];

    resp_tab[0] = 2'b00;
    resp_tab[1] = 2'b10;
    resp_tab[2] = 2'b11;

    aresetn    = 1'b0;
    cmd_tvalid = 1'b0;
    cmd_tdata  = '0;
    m_arready  = 1'b0;
    m_rvalid   = 1'b0;
    m_rdata    = '0;
    m_rresp    = '0;
    rsp_tready = 1'b0;

    // Reset values.
    repeat (3) @(negedge aclk);
    check("rst_cmd_tready", 64'(cmd_tready), 64'd0);
    check("rst_arvalid", 64'(m_arvalid), 64'd0);
    check("rst_araddr", 64'(m_araddr), 64'd0);
    check("rst_rready", 64'(m_rready), 64'd0);
    check("rst_rsp_tvalid", 64'(rsp_tvalid), 64'd0);
    check("rst_rsp_tdata", 64'(rsp_tdata), 64'd0);
    check("rst_rsp_tuser", 64'(rsp_tuser), 64'd0);
    aresetn = 1'b1;
    @(negedge aclk);
    check("rel_cmd_tready", 64'(cmd_tready), 64'd1);
    check("rel_rready", 64'(m_rready), 64'd1);

    // Zero-wait read; response handshake 3 edges after accept.
    run_read(12'h004, 0, 0, 0, 32'h5445_5354, 2'b00, 1'b0, 12'h000, a0);

    // Back-to-back with cmd_tvalid held high: one accept every 4 edges.
    run_read(12'h000, 0, 0, 0, 32'h0000_1111, 2'b00, 1'b1, 12'h004, a1);
    run_read(12'h004, 0, 0, 0, 32'h0000_2222, 2'b00, 1'b1, 12'h008, a2);
    run_read(12'h008, 0, 0, 0, 32'h0000_3333, 2'b00, 1'b0, 12'h000, a3);
    check("b2b_spacing_1", 64'(a2 - a1), 64'd4);
    check("b2b_spacing_2", 64'(a3 - a2), 64'd4);

    // Slow slave and a stalling consumer.
    run_read(12'h010, 5, 7, 10, 32'hCAFE_F00D, 2'b00, 1'b0, 12'h000, a0);

    // Error responses pass through unchanged.
    run_read(12'h020, 0, 0, 0, 32'hDEAD_BEEF, 2'b10, 1'b0, 12'h000, a0);
    run_read(12'h024, 2, 1, 1, 32'h1234_5678, 2'b11, 1'b0, 12'h000, a0);

    // Timeout boundaries: a handshake on the expiry cycle completes normally.
    run_read(12'h030, TMO - 1, 0, 0, 32'hA5A5_0030, 2'b00, 1'b0, 12'h000, a0);
    run_read(12'h034, 0, TMO - 1, 0, 32'hA5A5_0034, 2'b00, 1'b0, 12'h000, a0);
    run_read(12'h040, TMO, 0, 2, 32'hA5A5_0040, 2'b00, 1'b0, 12'h000, a0);
    run_read(12'h048, 0, 100, 0, 32'hA5A5_0048, 2'b00, 1'b0, 12'h000, a0);

    // Late beat from the aborted read arrives in IDLE and is discarded.
    m_rvalid = 1'b1;
    m_rdata  = 32'hBAD0_BAD0;
    m_rresp  = 2'b00;
    check("late_rready", 64'(m_rready), 64'd1);
    @(negedge aclk);
    m_rvalid = 1'b0;
    repeat (4) @(negedge aclk);
    check("late_no_rsp_valid", 64'(rsp_tvalid), 64'd0);
    check("late_no_rsp_count", 64'(obs_q.size()), 64'd0);
    check("late_cmd_tready", 64'(cmd_tready), 64'd1);

    // One-cycle reset while in DATA aborts with no response.
    cmd_tvalid = 1'b1;
    cmd_tdata  = 12'h0AC;
    check("mid_cmd_tready", 64'(cmd_tready), 64'd1);
    @(negedge aclk);
    cmd_tvalid = 1'b0;
    check("mid_arvalid", 64'(m_arvalid), 64'd1);
    m_arready = 1'b1;
    @(negedge aclk);
    m_arready = 1'b0;
    check("mid_rready_data", 64'(m_rready), 64'd1);
    @(negedge aclk);
    aresetn = 1'b0;
    @(negedge aclk);
    check("mid_rst_cmd_tready", 64'(cmd_tready), 64'd0);
    check("mid_rst_arvalid", 64'(m_arvalid), 64'd0);
    check("mid_rst_araddr", 64'(m_araddr), 64'd0);
    check("mid_rst_rready", 64'(m_rready), 64'd0);
    check("mid_rst_rsp_tvalid", 64'(rsp_tvalid), 64'd0);
    check("mid_rst_rsp_tdata", 64'(rsp_tdata), 64'd0);
    check("mid_rst_rsp_tuser", 64'(rsp_tuser), 64'd0);
    aresetn = 1'b1;
    @(negedge aclk);
    check("mid_rel_cmd_tready", 64'(cmd_tready), 64'd1);
    check("mid_no_rsp", 64'(obs_q.size()), 64'd0);
    run_read(12'h0AC, 1, 2, 0, 32'h600D_0AC0, 2'b00, 1'b0, 12'h000, a0);

    // Randomized reads, occasionally crossing the timeout in either phase.
    for (int i = 0; i < 24; i++) begin
      run_read(AW'($urandom), $urandom_range(0, TMO + 2), $urandom_range(0, TMO + 2),
               $urandom_range(0, 3), $urandom, resp_tab[$urandom_range(0, 2)],
               1'b0, 12'h000, a0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
